// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: request field layout
// and FSM state encoding.
package mem_arb_pkg;

  localparam int REQ_WIDTH = 25;
  localparam int RW_BIT    = 24;
  localparam int DATA_MSB  = 23;
  localparam int DATA_LSB  = 16;
  localparam int ADDR_MSB  = 15;
  localparam int ADDR_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector, purely combinational.
module rr_pick2 (
  input  logic [1:0] pending,
  input  logic       last_grant,
  input  logic       fixed_priority,
  output logic       winner
);

  // A lone requester wins outright; a tie goes to whoever was not served
  // last, or always to requester 0 when fixed priority is selected.
  always_comb begin
    winner = 1'b0;
    case (pending)
      2'b10:   winner = 1'b1;
      2'b11:   winner = fixed_priority ? 1'b0 : ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between two caches. One transaction at a
// time; four-phase handshake on both the requester and memory sides.
// Optional snoop invalidate broadcast: define MEM_ARB_SNOOP_INVALIDATE_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int LINE_WIDTH     = 16,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_WIDTH+ADDR_WIDTH:0] req0_request,
  input  logic                         req0_request_ready,
  output logic [LINE_WIDTH-1:0]        req0_response,
  output logic                         req0_response_ready,
  input  logic [DATA_WIDTH+ADDR_WIDTH:0] req1_request,
  input  logic                         req1_request_ready,
  output logic [LINE_WIDTH-1:0]        req1_response,
  output logic                         req1_response_ready,
  output logic [DATA_WIDTH+ADDR_WIDTH:0] memory_request,
  output logic                         memory_request_ready,
  input  logic [LINE_WIDTH-1:0]        memory_response,
  input  logic                         memory_response_ready,
  output logic [ADDR_WIDTH-1:0]        inv0_address,
  output logic                         inv0_valid,
  output logic [ADDR_WIDTH-1:0]        inv1_address,
  output logic                         inv1_valid,
  output logic                         grant,
  output logic                         busy
);

  localparam int RW_POS = DATA_WIDTH + ADDR_WIDTH;

  arb_state_t                state;
  logic                      last_grant;
  logic                      winner;
  logic [1:0]                pending;
  logic [RW_POS:0]           sel_req;
  logic [RW_POS:0]           req_q;
  logic                      owner_req_rdy;

  assign pending       = {req1_request_ready, req0_request_ready};
  assign sel_req       = winner ? req1_request : req0_request;
  assign owner_req_rdy = grant ? req1_request_ready : req0_request_ready;

  rr_pick2 u_pick (
    .pending        (pending),
    .last_grant     (last_grant),
    .fixed_priority (FIXED_PRIORITY != 0),
    .winner         (winner)
  );

  // Transaction FSM: pick an owner, hold its request to memory until memory
  // answers, then hold the response until both sides have released.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state                <= IDLE;
      last_grant           <= 1'b1;
      grant                <= 1'b1;
      req_q                <= '0;
      memory_request_ready <= 1'b0;
      req0_response        <= '0;
      req0_response_ready  <= 1'b0;
      req1_response        <= '0;
      req1_response_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            req_q                <= sel_req;
            grant                <= winner;
            memory_request_ready <= 1'b1;
            state                <= ISSUE;
          end
        end
        ISSUE: begin
          if (memory_response_ready) begin
            memory_request_ready <= 1'b0;
            if (grant) begin
              req1_response       <= memory_response;
              req1_response_ready <= 1'b1;
            end else begin
              req0_response       <= memory_response;
              req0_response_ready <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (!owner_req_rdy && !memory_response_ready) begin
            req0_response_ready <= 1'b0;
            req1_response_ready <= 1'b0;
            last_grant          <= grant;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign memory_request = req_q;
  assign busy           = (state != IDLE);

`ifdef MEM_ARB_SNOOP_INVALIDATE_EN
  // As a write is issued, strobe the other cache once with its address; the
  // address stays put until the next strobe to that cache.
  always_ff @(posedge clock) begin
    if (!reset) begin
      inv0_valid   <= 1'b0;
      inv1_valid   <= 1'b0;
      inv0_address <= '0;
      inv1_address <= '0;
    end else begin
      inv0_valid <= 1'b0;
      inv1_valid <= 1'b0;
      if (state == IDLE && |pending && sel_req[RW_POS]) begin
        if (winner) begin
          inv0_valid   <= 1'b1;
          inv0_address <= sel_req[ADDR_WIDTH-1:0];
        end else begin
          inv1_valid   <= 1'b1;
          inv1_address <= sel_req[ADDR_WIDTH-1:0];
        end
      end
    end
  end
`else
  assign inv0_valid   = 1'b0;
  assign inv1_valid   = 1'b0;
  assign inv0_address = '0;
  assign inv1_address = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions, hand
// sequences for multi-cycle corners, and a randomized run against a
// transaction-level arbitration model.
module tb_mem_arbiter;

`ifdef MEM_ARB_SNOOP_INVALIDATE_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // main DUT (round-robin)
  logic [1:0][24:0] rq;
  logic [1:0]       rqv;
  logic [1:0][15:0] rsp;
  logic [1:0]       rsp_rdy;
  logic [24:0]      memory_request;
  logic             memory_request_ready;
  logic [15:0]      memory_response;
  logic             memory_response_ready;
  logic [15:0]      inv0_address, inv1_address;
  logic             inv0_valid, inv1_valid;
  logic             grant, busy;

  mem_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clock(clock), .reset(reset),
    .req0_request(rq[0]), .req0_request_ready(rqv[0]),
    .req0_response(rsp[0]), .req0_response_ready(rsp_rdy[0]),
    .req1_request(rq[1]), .req1_request_ready(rqv[1]),
    .req1_response(rsp[1]), .req1_response_ready(rsp_rdy[1]),
    .memory_request(memory_request), .memory_request_ready(memory_request_ready),
    .memory_response(memory_response), .memory_response_ready(memory_response_ready),
    .inv0_address(inv0_address), .inv0_valid(inv0_valid),
    .inv1_address(inv1_address), .inv1_valid(inv1_valid),
    .grant(grant), .busy(busy)
  );

  // fixed-priority DUT
  logic [24:0] f_rq0, f_rq1, f_mreq;
  logic [1:0]  f_rqv, f_rsp_rdy;
  logic [15:0] f_rsp0, f_rsp1, f_md, f_inv0a, f_inv1a;
  logic        f_mrr, f_mrdy, f_inv0v, f_inv1v, f_grant, f_busy;

  mem_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clock(clock), .reset(reset),
    .req0_request(f_rq0), .req0_request_ready(f_rqv[0]),
    .req0_response(f_rsp0), .req0_response_ready(f_rsp_rdy[0]),
    .req1_request(f_rq1), .req1_request_ready(f_rqv[1]),
    .req1_response(f_rsp1), .req1_response_ready(f_rsp_rdy[1]),
    .memory_request(f_mreq), .memory_request_ready(f_mrr),
    .memory_response(f_md), .memory_response_ready(f_mrdy),
    .inv0_address(f_inv0a), .inv0_valid(f_inv0v),
    .inv1_address(f_inv1a), .inv1_valid(f_inv1v),
    .grant(f_grant), .busy(f_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0][15:0] ea;  // expected held invalidate addresses

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0; rqv = '0; memory_response_ready = 1'b0; f_rqv = '0; f_mrdy = 1'b0;
    ea = '0;
    repeat (2) @(negedge clock);
    chk("rst_mreq", memory_request, 0);
    chk("rst_mrr", memory_request_ready, 0);
    chk("rst_rsp_rdy", rsp_rdy, 0);
    chk("rst_rsp", {rsp[1], rsp[0]}, 0);
    chk("rst_grant", grant, 1);
    chk("rst_busy", busy, 0);
    chk("rst_inv", {inv1_valid, inv0_valid, inv1_address ^ inv0_address}, 0);
    reset = 1'b1;
  endtask

  task automatic chk_inv(input logic [24:0] er, input int own, input bit first);
    logic [1:0] ev;
    ev = '0;
    if (SNOOP && first && er[24]) begin
      ev[1-own] = 1'b1;
      ea[1-own] = er[15:0];
    end
    chk("inv_valid", {inv1_valid, inv0_valid}, ev);
    chk("inv_addr", {inv1_address, inv0_address}, ea);
  endtask

  typedef struct {
    logic [1:0]  pend;
    logic [24:0] r0, r1;
    logic [15:0] md;
    int          dly;
    int          own;
  } vec_t;

  // One complete transaction with directed timing checks.
  task automatic do_txn(input vec_t v);
    logic [24:0] er;
    logic [1:0]  om;
    @(negedge clock);
    rq[0] = v.r0; rq[1] = v.r1; rqv = v.pend;
    er = v.own ? v.r1 : v.r0;
    om = v.own ? 2'b10 : 2'b01;
    @(negedge clock);
    chk("issue_rdy", memory_request_ready, 1);
    chk("grant", grant, v.own);
    chk("mem_req", memory_request, er);
    chk("busy", busy, 1);
    chk_inv(er, v.own, 1'b1);
    for (int i = 0; i < v.dly; i++) begin
      @(negedge clock);
      chk("hold_req", {memory_request_ready, memory_request}, {1'b1, er});
      chk("early_rsp", rsp_rdy, 0);
      chk_inv(er, v.own, 1'b0);
    end
    memory_response = v.md; memory_response_ready = 1'b1;
    @(negedge clock);
    chk("rsp_rdy", rsp_rdy, om);
    chk("rsp", rsp[v.own], v.md);
    chk("mrr_drop", memory_request_ready, 0);
    chk_inv(er, v.own, 1'b0);
    rqv = '0; memory_response_ready = 1'b0;
    @(negedge clock);
    chk("release", rsp_rdy, 0);
    chk("idle", busy, 0);
  endtask

  // Randomized traffic vs. a transaction-level model of the arbitration rule.
  task automatic run_random(input int ncyc);
    int last, own, cnt, hold, wd;
    bit inflight, got;
    logic [24:0] exp_req;
    logic [15:0] exp_rsp;
    int wait_c [2];
    apply_reset();
    last = 1; own = 0; cnt = 0; hold = 0; wd = 0; inflight = 0; got = 0;
    exp_req = '0; exp_rsp = '0; wait_c[0] = 0; wait_c[1] = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      if (inflight && got && !rsp_rdy[own]) begin
        chk("rnd_release", rqv[own], 0);
        inflight = 0; got = 0;
      end
      for (int k = 0; k < 2; k++)
        if (rsp_rdy[k] && !(inflight && k == own)) chk("rnd_spurious_rsp", k, own);
      if (inflight && memory_response_ready) chk("rnd_rsp_latency", rsp_rdy[own], 1);
      if (inflight && !got && rsp_rdy[own]) begin
        got = 1;
        chk("rnd_rsp", rsp[own], exp_rsp);
        hold = $urandom_range(0, 2);
      end else if (got && rsp_rdy[own]) begin
        chk("rnd_rsp_hold", rsp[own], exp_rsp);
      end
      if (memory_request_ready && !inflight) begin
        own = (rqv == 2'b11) ? 1 - last : (rqv[1] ? 1 : 0);
        chk("rnd_pending", rqv != 2'b00, 1);
        chk("rnd_grant", grant, own);
        chk("rnd_mreq", memory_request, rq[own]);
        last = own; inflight = 1; got = 0; wd = 0;
        cnt = $urandom_range(0, 3); exp_req = rq[own]; wait_c[own] = 0;
      end
      if (inflight && memory_request_ready) chk("rnd_mreq_stable", memory_request, exp_req);
      if (memory_response_ready && !memory_request_ready) begin
        memory_response_ready = 1'b0;
      end else if (inflight && memory_request_ready && !memory_response_ready) begin
        if (cnt == 0) begin
          memory_response = 16'($urandom);
          exp_rsp = memory_response;
          memory_response_ready = 1'b1;
        end else cnt--;
      end
      if (got && rsp_rdy[own] && rqv[own]) begin
        if (hold == 0) rqv[own] = 1'b0; else hold--;
      end
      for (int k = 0; k < 2; k++) begin
        if (!rqv[k] && !(inflight && k == own) && $urandom_range(0, 2) == 0) begin
          rq[k] = 25'($urandom); rqv[k] = 1'b1; wait_c[k] = 0;
        end
        if (rqv[k] && !(inflight && k == own)) begin
          wait_c[k]++;
          if (wait_c[k] > 40) begin chk("rnd_starve", k, 2); wait_c[k] = 0; end
        end
      end
      if (inflight) wd++;
      if (wd > 30) begin chk("rnd_timeout", wd, 0); break; end
    end
  endtask

  initial begin
    vec_t tbl [6];
    rq = '0; rqv = '0; memory_response = '0; memory_response_ready = 1'b0;
    f_rq0 = '0; f_rq1 = '0; f_rqv = '0; f_md = '0; f_mrdy = 1'b0; ea = '0;

    tbl[0] = '{2'b01, {1'b0, 8'h00, 16'h000C}, 25'h0, 16'h3837, 0, 0};
    tbl[1] = '{2'b11, {1'b0, 8'h00, 16'h0010}, {1'b0, 8'h00, 16'h0020}, 16'h1111, 0, 1};
    tbl[2] = '{2'b11, {1'b0, 8'h00, 16'h0010}, {1'b0, 8'h00, 16'h0020}, 16'h2222, 0, 0};
    tbl[3] = '{2'b10, 25'h0, {1'b1, 8'hA5, 16'h1234}, 16'hBEEF, 7, 1};
    tbl[4] = '{2'b01, {1'b1, 8'h0F, 16'h0010}, 25'h0, 16'h0F0F, 2, 0};
    tbl[5] = '{2'b11, {1'b0, 8'h00, 16'hFFFE}, {1'b1, 8'h5A, 16'hFFFF}, 16'hCAFE, 1, 1};

    apply_reset();
    chk("reset_memreq_exact", memory_request, 25'h000000C & 25'h0);
    for (int i = 0; i < 6; i++) do_txn(tbl[i]);

    // simultaneous requests after reset: req0, then req1 one idle cycle later, then req0
    apply_reset();
    @(negedge clock);
    rq[0] = 25'h0010; rq[1] = 25'h0020; rqv = 2'b11;
    @(negedge clock);
    chk("tie_grant0", grant, 0);
    chk("tie_mreq0", memory_request, 25'h0010);
    memory_response = 16'h4142; memory_response_ready = 1'b1;
    @(negedge clock);
    chk("tie_rsp0", {rsp_rdy, rsp[0]}, {2'b01, 16'h4142});
    rqv[0] = 1'b0; memory_response_ready = 1'b0;
    @(negedge clock);
    chk("tie_gap", {busy, rsp_rdy}, 0);
    @(negedge clock);
    chk("tie_issue1", {memory_request_ready, grant, memory_request}, {2'b11, 25'h0020});
    memory_response = 16'h5152; memory_response_ready = 1'b1;
    @(negedge clock);
    chk("tie_rsp1", {rsp_rdy, rsp[1]}, {2'b10, 16'h5152});
    rqv[1] = 1'b0; memory_response_ready = 1'b0;
    @(negedge clock);
    do_txn('{2'b11, 25'h0010, 25'h0020, 16'h6162, 0, 0});

    // reset while ISSUE is active, then a clean req1 read
    @(negedge clock);
    rq[0] = {1'b1, 8'h33, 16'h0400}; rqv = 2'b01;
    @(negedge clock);
    chk("mid_issue", memory_request_ready, 1);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_mem", {memory_request_ready, memory_request}, 0);
    chk("mid_rst_rsp", {rsp_rdy, rsp[1], rsp[0]}, 0);
    chk("mid_rst_state", {busy, grant}, 2'b01);
    ea = '0;
    chk_inv(25'h0, 0, 1'b0);
    reset = 1'b1; rqv = '0;
    do_txn('{2'b10, 25'h0, {1'b0, 8'h00, 16'hFFFE}, 16'h7788, 0, 1});

    // fixed priority: req0 keeps re-requesting, req1 must wait
    apply_reset();
    @(negedge clock);
    f_rq0 = 25'h0010; f_rq1 = 25'h0020; f_rqv = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("fp_issue", {f_mrr, f_grant, f_mreq}, {2'b10, 25'h0010});
      f_md = 16'(k + 16'h0A00); f_mrdy = 1'b1;
      @(negedge clock);
      chk("fp_rsp", {f_rsp_rdy, f_rsp0}, {2'b01, 16'(k + 16'h0A00)});
      f_rqv[0] = 1'b0; f_mrdy = 1'b0;
      @(negedge clock);
      chk("fp_no_req1", f_rsp_rdy, 0);
      f_rqv[0] = 1'b1;
    end
    f_rqv = '0;

    run_random(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single backing-memory port between two cache instances (e.g. I-cache and D-cache).
- Accepts 25-bit requests {rw, data[7:0], addr[15:0]} in the same format the cache emits on memory_request.
- Forwards one request at a time to memory and returns the 16-bit line to the owner.
- Optionally broadcasts a write address to the other cache's invalidate input.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 8, write data byte width
LINE_WIDTH, 16, memory response (cache line) width
FIXED_PRIORITY, 0, 0 = round-robin; 1 = requester 0 always wins ties

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
req0_request  in  25  {rw, data, addr} from requester 0 (rw=1 write)
req0_request_ready  in  1  requester 0 request valid, level, held until response handshake completes
req0_response  out  16  line returned to requester 0
req0_response_ready  out  1  response valid to requester 0
req1_request  in  25  as req0
req1_request_ready  in  1  as req0
req1_response  out  16  as req0
req1_response_ready  out  1  as req0
memory_request  out  25  forwarded request
memory_request_ready  out  1  forwarded request valid
memory_response  in  16  line from memory
memory_response_ready  in  1  memory response valid, level
inv0_address  out  16  invalidate address to requester 0
inv0_valid  out  1  one-cycle invalidate strobe to requester 0
inv1_address  out  16  as inv0, to requester 1
inv1_valid  out  1  as inv0
grant  out  1  index of current or last owner
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (reset==0 at a clock edge), including mid-transaction: state IDLE, abandons any transaction, no replay. All outputs 0. grant=1 (last_grant=1, so req0 wins the first tie).
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If any request_ready is high, select an owner: the only pending requester; on a tie, the requester != last_grant (FIXED_PRIORITY=1: always 0).
  - Latch that requester's 25-bit request into an internal register.
  - Set grant = owner and move to ISSUE. One cycle from request_ready sampled to memory_request_ready high.
- ISSUE:
  - memory_request_ready=1; memory_request = latched value, held stable.
  - On memory_response_ready==1: latch memory_response, drop memory_request_ready, set owner's response_ready=1, go to DONE.
  - Response appears one cycle after memory_response_ready is sampled.
- DONE:
  - Owner's response and response_ready held stable.
  - Leave for IDLE when both the owner's request_ready==0 and memory_response_ready==0 (four-phase handshake on both sides). On that edge: response_ready=0, last_grant=owner.
- Non-owner request_ready stays pending untouched; it is served on the next IDLE. Round-robin guarantees a wait of at most one transaction.
- Request changes while a requester is not yet granted: only the value at grant time is latched.
- The arbiter does not modify addresses or data. Odd/even address alignment is the memory's concern.
- busy = (state != IDLE).

Optional Feature:
Macro MEM_ARB_SNOOP_INVALIDATE_EN.
- Defined: on the IDLE->ISSUE edge, if latched rw==1, pulse the other requester's invK_valid for exactly one cycle. invK_address = latched addr; it holds its value until the next strobe.
- Not defined: inv*_valid and inv*_address are tied to 0, and the logic is absent.

Decomposition:
- Package mem_arb_pkg:
  - REQ_WIDTH=25.
  - Field positions RW_BIT=24, DATA_MSB=23/DATA_LSB=16, ADDR_MSB=15/ADDR_LSB=0.
  - State encoding constants IDLE/ISSUE/DONE.
- One sub-module: rr_pick2, a combinational 2-way round-robin selector (inputs pending[1:0], last_grant, fixed_priority; output winner). Everything else is inline.

Test Plan:
- Reset then single read: req0 {0,0,0x000C} held high; memory returns 0x3837 one cycle after request -> memory_request==0x000000C, req0_response==0x3837, req0_response_ready high until req0 drops; grant=0.
- Simultaneous requests after reset: req0 read 0x0010, req1 read 0x0020 raised same cycle -> req0 served first, then req1 with no IDLE gap beyond one cycle; third tie goes to req0 again (alternation).
- FIXED_PRIORITY=1: req0 kept continuously re-requesting, req1 pending -> req1 never granted while req0 requests; grant stays 0.
- Reset mid-ISSUE: drop reset while memory_request_ready=1 -> next cycle all outputs 0, state IDLE; subsequent req1 read 0xFFFE completes normally.
- Slow memory: memory_response_ready delayed 7 cycles -> memory_request stable all 7 cycles; response_ready rises exactly one cycle after memory_response_ready.
- With MEM_ARB_SNOOP_INVALIDATE_EN: req0 write {1,0x0F,0x0010} -> inv1_valid high exactly one cycle with inv1_address=0x0010, inv0_valid stays 0; a read produces no strobe. Without the macro: inv* stay 0.
